bp_fetch_seq: RTL and testbench

- Fetch request sequencer directly downstream of the branch-target buffer.
- Consumes the CFG_BP_DEPTH-long predicted address sequence and picks the first address not already requested.
- Issues that address to the instruction cache with a valid/ready handshake, and tracks in-flight requests in an ordered pending queue.
- Drives the next prediction start address back to the BTB.

---
 rtl/bp_fetch_seq.sv | 166 ++++++++++++++++
 tb/tb_bp_fetch_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fetch_seq.sv
// Fetch request sequencer between the BTB and the instruction cache.
// Optional statistics counters are built when BP_FETCH_SEQ_STAT_EN is defined.
module bp_fetch_seq #(
   parameter int DEPTH  = 5,
   parameter int XLEN   = 64,
   parameter int QDEPTH = 4
) (
   input  logic                    i_clk,
   input  logic                    i_nrst,
   input  logic                    i_flush,
   input  logic [XLEN-1:0]         i_flush_pc,
   input  logic [DEPTH*XLEN-1:0]   i_bp_npc,
   input  logic [DEPTH-1:0]        i_bp_exec,
   output logic [XLEN-1:0]         o_bp_pc,
   output logic                    o_req_valid,
   input  logic                    i_req_ready,
   output logic [XLEN-1:0]         o_req_addr,
   output logic                    o_req_exec,
   input  logic                    i_resp_valid,
   input  logic [XLEN-1:0]         i_resp_addr,
   output logic [$clog2(QDEPTH):0] o_pend_cnt,
   output logic                    o_resp_err
`ifdef BP_FETCH_SEQ_STAT_EN
   ,
   output logic [31:0]             o_stat_req,
   output logic [31:0]             o_stat_skip
`endif
);

   localparam int QW = $clog2(QDEPTH);
   localparam int CW = QW + 1;
   localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {RUN, DRAIN} state_t;

   state_t            state;
   logic [XLEN-1:0]   q_addr [QDEPTH];
   logic [QDEPTH-1:0] q_vld;
   logic [QW-1:0]     wr_ptr;
   logic [QW-1:0]     rd_ptr;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     disc_cnt;
   logic [XLEN-1:0]   last_issued;
   logic [XLEN-1:0]   bp_pc;
   logic              resp_err;

   logic [XLEN-1:0]   slot_addr [DEPTH];
   logic [DEPTH-1:0]  slot_dup;
   logic              sel_found;
   logic [SW-1:0]     sel_idx;
   logic              full;
   logic              fire;
   logic              head_match;
   logic              push;
   logic              pop;

   // A slot is a duplicate if it is still in flight or was the most recent issue.
   always_comb begin
      slot_dup = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_addr[i] = i_bp_npc[i*XLEN +: XLEN];
         if (slot_addr[i] == last_issued) slot_dup[i] = 1'b1;
         for (int j = 0; j < QDEPTH; j++) begin
            if (q_vld[j] && (q_addr[j] == slot_addr[i])) slot_dup[i] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!slot_dup[i]) begin
            sel_found = 1'b1;
            sel_idx   = SW'(i);
         end
      end
   end

   assign full        = (cnt == CW'(QDEPTH));
   assign o_req_valid = (state == RUN) && sel_found && !full;
   assign o_req_addr  = slot_addr[sel_idx];
   assign o_req_exec  = i_bp_exec[sel_idx];
   assign fire        = o_req_valid && i_req_ready;
   assign head_match  = (cnt != '0) && (i_resp_addr == q_addr[rd_ptr]);
   assign push        = fire && !i_flush;
   assign pop         = (state == RUN) && !i_flush && i_resp_valid && head_match;

   assign o_bp_pc     = bp_pc;
   assign o_pend_cnt  = cnt;
   assign o_resp_err  = resp_err;

   // A flush-cycle transfer still reaches the cache, so it is counted as a discard.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state       <= RUN;
         for (int i = 0; i < QDEPTH; i++) q_addr[i] <= '0;
         q_vld       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cnt         <= '0;
         disc_cnt    <= '0;
         last_issued <= '0;
         bp_pc       <= '0;
         resp_err    <= 1'b0;
      end else begin
         resp_err <= 1'b0;
         if (i_flush) begin
            bp_pc       <= i_flush_pc;
            last_issued <= '1;
            q_vld       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            if (state == RUN) begin
               disc_cnt <= cnt + CW'(fire);
               state    <= ((cnt != '0) || fire) ? DRAIN : RUN;
            end else if (i_resp_valid && (disc_cnt != '0)) begin
               disc_cnt <= disc_cnt - CW'(1);
               if (disc_cnt == CW'(1)) state <= RUN;
            end
         end else if (state == DRAIN) begin
            if (i_resp_valid && (disc_cnt != '0)) begin
               disc_cnt <= disc_cnt - CW'(1);
               if (disc_cnt == CW'(1)) state <= RUN;
            end
         end else begin
            if (push) begin
               q_addr[wr_ptr] <= o_req_addr;
               q_vld[wr_ptr]  <= 1'b1;
               wr_ptr         <= wr_ptr + QW'(1);
               last_issued    <= o_req_addr;
               bp_pc          <= o_req_addr;
            end
            if (pop) begin
               q_vld[rd_ptr] <= 1'b0;
               rd_ptr        <= rd_ptr + QW'(1);
            end
            if (i_resp_valid && !head_match) resp_err <= 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
         end
      end
   end

`ifdef BP_FETCH_SEQ_STAT_EN
   logic [31:0] stat_req;
   logic [31:0] stat_skip;

   // Free-running counters; a flush does not clear them.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         stat_req  <= '0;
         stat_skip <= '0;
      end else begin
         if (fire) stat_req <= stat_req + 32'd1;
         if (fire && (sel_idx != '0)) stat_skip <= stat_skip + 32'd1;
      end
   end

   assign o_stat_req  = stat_req;
   assign o_stat_skip = stat_skip;
`else
   // Default build carries no statistics counters.
`endif

endmodule

// File: tb/tb_bp_fetch_seq.sv
// Directed self-checking bench for bp_fetch_seq: a request scoreboard plus a
// model of the pending queue drive the expected values.
module tb_bp_fetch_seq;

   localparam int DEPTH  = 5;
   localparam int XLEN   = 64;
   localparam int QDEPTH = 4;
   localparam int CW     = $clog2(QDEPTH) + 1;

   logic                  i_clk;
   logic                  i_nrst;
   logic                  i_flush;
   logic [XLEN-1:0]       i_flush_pc;
   logic [DEPTH*XLEN-1:0] i_bp_npc;
   logic [DEPTH-1:0]      i_bp_exec;
   logic [XLEN-1:0]       o_bp_pc;
   logic                  o_req_valid;
   logic                  i_req_ready;
   logic [XLEN-1:0]       o_req_addr;
   logic                  o_req_exec;
   logic                  i_resp_valid;
   logic [XLEN-1:0]       i_resp_addr;
   logic [CW-1:0]         o_pend_cnt;
   logic                  o_resp_err;
`ifdef BP_FETCH_SEQ_STAT_EN
   logic [31:0]           o_stat_req;
   logic [31:0]           o_stat_skip;
`endif

   bp_fetch_seq #(.DEPTH(DEPTH), .XLEN(XLEN), .QDEPTH(QDEPTH)) dut (
      .i_clk        (i_clk),
      .i_nrst       (i_nrst),
      .i_flush      (i_flush),
      .i_flush_pc   (i_flush_pc),
      .i_bp_npc     (i_bp_npc),
      .i_bp_exec    (i_bp_exec),
      .o_bp_pc      (o_bp_pc),
      .o_req_valid  (o_req_valid),
      .i_req_ready  (i_req_ready),
      .o_req_addr   (o_req_addr),
      .o_req_exec   (o_req_exec),
      .i_resp_valid (i_resp_valid),
      .i_resp_addr  (i_resp_addr),
      .o_pend_cnt   (o_pend_cnt),
      .o_resp_err   (o_resp_err)
`ifdef BP_FETCH_SEQ_STAT_EN
      ,
      .o_stat_req   (o_stat_req),
      .o_stat_skip  (o_stat_skip)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [XLEN-1:0] exp_q  [$];
   logic [XLEN-1:0] pend_q [$];

   task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                              input logic [XLEN-1:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rdy, input logic rv, input logic [XLEN-1:0] raddr,
                                input logic fl, input logic [XLEN-1:0] fpc);
      i_req_ready  = rdy;
      i_resp_valid = rv;
      i_resp_addr  = raddr;
      i_flush      = fl;
      i_flush_pc   = fpc;
   endtask

   task automatic setNpc(input logic [XLEN-1:0] base);
      for (int i = 0; i < DEPTH; i++) i_bp_npc[i*XLEN +: XLEN] = base + XLEN'(4 * i);
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Compare the offered request against the scoreboard head and record it as pending.
   task automatic checkIssue(input string tag);
      logic [XLEN-1:0] exp_addr;
      checkOutput({tag, "_valid"}, XLEN'(o_req_valid), 1);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("[TB] FAIL %s_sb: observed empty scoreboard expected an entry", tag);
      end else begin
         exp_addr = exp_q.pop_front();
         checkOutput({tag, "_addr"}, o_req_addr, exp_addr);
         if (i_req_ready && !i_flush) pend_q.push_back(exp_addr);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [XLEN-1:0] a;
      i_nrst    = 1'b0;
      i_bp_npc  = '0;
      i_bp_exec = '0;
      applyStimulus(0, 0, 0, 0, 0);
      repeat (2) tick();

      checkOutput("rst_pend",  XLEN'(o_pend_cnt), 0);
      checkOutput("rst_valid", XLEN'(o_req_valid), 0);
      checkOutput("rst_err",   XLEN'(o_resp_err), 0);
      checkOutput("rst_bp_pc", o_bp_pc, 0);
      i_nrst = 1'b1;
      tick();
      checkOutput("idle_valid", XLEN'(o_req_valid), 0);

      // Load the start address, then issue two in a row.
      setNpc(64'h1000);
      i_bp_exec = 5'b00010;
      applyStimulus(0, 0, 0, 1, 64'h1000);
      tick();
      checkOutput("flush_bp_pc", o_bp_pc, 64'h1000);
      applyStimulus(1, 0, 0, 0, 0);
      exp_q.push_back(64'h1000);
      settle();
      checkIssue("first");
      checkOutput("first_exec", XLEN'(o_req_exec), 0);
      tick();
      exp_q.push_back(64'h1004);
      checkIssue("second");
      checkOutput("second_exec", XLEN'(o_req_exec), 1);
      checkOutput("second_pend", XLEN'(o_pend_cnt), XLEN'(pend_q.size() - 1));
      checkOutput("second_bp_pc", o_bp_pc, 64'h1000);
      tick();
      applyStimulus(0, 1, pend_q[0], 0, 0);
      settle();
      checkOutput("two_pend", XLEN'(o_pend_cnt), XLEN'(pend_q.size()));
      checkOutput("two_bp_pc", o_bp_pc, 64'h1004);
      void'(pend_q.pop_front());
      tick();
      checkOutput("resp1_pend", XLEN'(o_pend_cnt), XLEN'(pend_q.size()));
      applyStimulus(0, 1, pend_q[0], 0, 0);
      void'(pend_q.pop_front());
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("resp2_pend", XLEN'(o_pend_cnt), 0);
      checkOutput("resp2_err",  XLEN'(o_resp_err), 0);

      // Request held while the cache stalls.
      setNpc(64'h2000);
      settle();
      for (int k = 0; k < 3; k++) begin
         checkOutput("hold_valid", XLEN'(o_req_valid), 1);
         checkOutput("hold_addr",  o_req_addr, 64'h2000);
         checkOutput("hold_pend",  XLEN'(o_pend_cnt), 0);
         tick();
      end

      // Fill the queue to full.
      setNpc(64'h1000);
      applyStimulus(1, 0, 0, 0, 0);
      settle();
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(64'h1000 + XLEN'(4 * k));
         checkIssue("fill");
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0);
      settle();
      checkOutput("full_pend",  XLEN'(o_pend_cnt), 4);
      checkOutput("full_valid", XLEN'(o_req_valid), 0);

      // Out-of-order response raises a single-cycle error.
      applyStimulus(0, 1, 64'h3000, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("ooo_err",  XLEN'(o_resp_err), 1);
      checkOutput("ooo_pend", XLEN'(o_pend_cnt), 4);
      tick();
      checkOutput("ooo_err_clr", XLEN'(o_resp_err), 0);
      applyStimulus(0, 1, pend_q[0], 0, 0);
      void'(pend_q.pop_front());
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      settle();
      checkOutput("pop_pend",  XLEN'(o_pend_cnt), 3);
      checkOutput("pop_valid", XLEN'(o_req_valid), 1);
      checkOutput("pop_addr",  o_req_addr, 64'h1000);

      // Flush together with a transfer: three pending plus one discard.
      applyStimulus(1, 0, 0, 1, 64'h8000);
      tick();
      pend_q.delete();
      applyStimulus(0, 0, 0, 0, 0);
      setNpc(64'h8000);
      settle();
      checkOutput("drain_valid", XLEN'(o_req_valid), 0);
      checkOutput("drain_pend",  XLEN'(o_pend_cnt), 0);
      checkOutput("drain_bp_pc", o_bp_pc, 64'h8000);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) checkOutput("drain_last_valid", XLEN'(o_req_valid), 0);
         applyStimulus(0, 1, 64'h1004 + XLEN'(4 * k), 0, 0);
         tick();
         applyStimulus(0, 0, 0, 0, 0);
         checkOutput("drain_err", XLEN'(o_resp_err), 0);
      end
      settle();
      checkOutput("run_valid", XLEN'(o_req_valid), 1);
      checkOutput("run_addr",  o_req_addr, 64'h8000);
      checkOutput("run_bp_pc", o_bp_pc, 64'h8000);

      // Response with nothing pending.
      applyStimulus(0, 1, 64'h8000, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("empty_err",  XLEN'(o_resp_err), 1);
      checkOutput("empty_pend", XLEN'(o_pend_cnt), 0);

      // Streaming with push and pop together at occupancy 2; pointers wrap.
      for (int k = 0; k < 11; k++) begin
         a = 64'h9000 + XLEN'(64 * k);
         setNpc(a);
         exp_q.push_back(a);
         if (k >= 2) applyStimulus(1, 1, pend_q[0], 0, 0);
         else applyStimulus(1, 0, 0, 0, 0);
         settle();
         checkOutput("stream_pend", XLEN'(o_pend_cnt), XLEN'(pend_q.size()));
         checkIssue("stream");
         if (k >= 2) void'(pend_q.pop_front());
         tick();
         checkOutput("stream_err", XLEN'(o_resp_err), 0);
      end
      while (pend_q.size() != 0) begin
         applyStimulus(0, 1, pend_q[0], 0, 0);
         void'(pend_q.pop_front());
         tick();
         checkOutput("tail_err", XLEN'(o_resp_err), 0);
      end
      applyStimulus(0, 0, 0, 0, 0);
      settle();
      checkOutput("tail_pend", XLEN'(o_pend_cnt), 0);

`ifdef BP_FETCH_SEQ_STAT_EN
      checkOutput("stat_req",  XLEN'(o_stat_req), 18);
      checkOutput("stat_skip", XLEN'(o_stat_skip), 4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
